// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizing for the ROB writeback arbiter.
// The interface, the picker and the top all take their widths from here.
package wb_arbiter_pkg;

    localparam int unsigned NUM_REQ    = 6;
    localparam int unsigned SUPER      = 2;
    localparam int unsigned ROB_SZ     = 32;
    localparam int unsigned PHYS_SZ    = 64;
    localparam int unsigned STARVE_MAX = 7;

    localparam int unsigned ROBW = $clog2(ROB_SZ);
    localparam int unsigned SRCW = $clog2(NUM_REQ);
    localparam int unsigned CNTW = $clog2(STARVE_MAX + 1);

    typedef logic [31:0]         word_t;
    typedef logic [ROBW-1:0]     rob_idx_t;
    typedef logic [SRCW-1:0]     src_t;
    typedef logic [CNTW-1:0]     wait_cnt_t;
    typedef logic [NUM_REQ-1:0]  req_mask_t;

    // Requester index + 1, wrapping at NUM_REQ (not a power of two).
    function automatic src_t next_src(input src_t idx);
        return (idx == src_t'(NUM_REQ - 1)) ? '0 : idx + src_t'(1);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Requester-side and ROB-side signals of the writeback arbiter.
// The master modport is the requester/ROB view; the slave modport is the arbiter.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    req_mask_t                req_valid;
    rob_idx_t [NUM_REQ-1:0]   req_rob;
    word_t    [NUM_REQ-1:0]   req_data;
    req_mask_t                req_ready;

    logic     [SUPER-1:0]     wb_valid;
    rob_idx_t [SUPER-1:0]     wb_rob;
    word_t    [SUPER-1:0]     wb_data;
    src_t     [SUPER-1:0]     wb_src;

    modport master (
        output req_valid, req_rob, req_data,
        input  req_ready, wb_valid, wb_rob, wb_data, wb_src
    );

    modport slave (
        input  req_valid, req_rob, req_data,
        output req_ready, wb_valid, wb_rob, wb_data, wb_src
    );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Returns the first set bit of i_mask at or after i_start, wrapping modulo NUM_REQ.
// i_start must be below NUM_REQ.
module wb_arbiter_rr_pick
    import wb_arbiter_pkg::*;
(
    input  req_mask_t i_mask,
    input  src_t      i_start,
    output src_t      o_idx,
    output logic      o_found
);

    always_comb begin
        int unsigned w_pos;
        w_pos   = 0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_pos = 32'(i_start) + off;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (!o_found && i_mask[w_pos]) begin
                o_found = 1'b1;
                o_idx   = src_t'(w_pos);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Shares SUPER ROB writeback ports among NUM_REQ result requesters.
// Starving requesters are granted first, then round-robin from r_rr_ptr.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_wb_stall,
    wb_arbiter_if.slave io_bus
);

    src_t                      r_rr_ptr;
    wait_cnt_t [NUM_REQ-1:0]   r_wait_cnt;
    logic      [SUPER-1:0]     r_wb_valid;
    rob_idx_t  [SUPER-1:0]     r_wb_rob;
    word_t     [SUPER-1:0]     r_wb_data;
    src_t      [SUPER-1:0]     r_wb_src;

    logic                      w_grant_en;
    req_mask_t                 w_promo;
    req_mask_t [SUPER:0]       w_avail;
    src_t      [SUPER-1:0]     w_promo_idx;
    src_t      [SUPER-1:0]     w_rr_idx;
    src_t      [SUPER-1:0]     w_sel_idx;
    logic      [SUPER-1:0]     w_promo_found;
    logic      [SUPER-1:0]     w_rr_found;
    logic      [SUPER-1:0]     w_sel_found;
    req_mask_t                 w_ready;
    src_t                      w_last;
    logic                      w_any;

    assign w_grant_en = !rst && !i_flush && !i_wb_stall;
    assign w_avail[0] = w_grant_en ? io_bus.req_valid : '0;

    always_comb begin
        w_promo = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_promo[i] = w_avail[0][i] && (r_wait_cnt[i] == wait_cnt_t'(STARVE_MAX));
        end
    end

    // Each port removes its grant from the candidate set seen by the next port.
    for (genvar k = 0; k < SUPER; k++) begin : g_port
        wb_arbiter_rr_pick u_promo_pick (
            .i_mask  (w_avail[k] & w_promo),
            .i_start ('0),
            .o_idx   (w_promo_idx[k]),
            .o_found (w_promo_found[k])
        );

        wb_arbiter_rr_pick u_rr_pick (
            .i_mask  (w_avail[k]),
            .i_start (r_rr_ptr),
            .o_idx   (w_rr_idx[k]),
            .o_found (w_rr_found[k])
        );

        assign w_sel_idx[k]   = w_promo_found[k] ? w_promo_idx[k] : w_rr_idx[k];
        assign w_sel_found[k] = w_promo_found[k] | w_rr_found[k];
        assign w_avail[k+1]   = w_avail[k]
                              & ~(w_sel_found[k] ? (req_mask_t'(1) << w_sel_idx[k]) : '0);
    end

    assign w_ready          = w_avail[0] & ~w_avail[SUPER];
    assign io_bus.req_ready = w_ready;

    always_comb begin
        w_any  = 1'b0;
        w_last = r_rr_ptr;
        for (int k = 0; k < SUPER; k++) begin
            if (w_sel_found[k]) begin
                w_any  = 1'b1;
                w_last = w_sel_idx[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_wait_cnt <= '0;
            r_wb_valid <= '0;
            r_wb_rob   <= '0;
            r_wb_data  <= '0;
            r_wb_src   <= '0;
        end else begin
            if (w_any) begin
                r_rr_ptr <= next_src(w_last);
            end

            // Stall still ages waiting requesters, so long stalls feed promotion.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i_flush || !io_bus.req_valid[i] || w_ready[i]) begin
                    r_wait_cnt[i] <= '0;
                end else if (r_wait_cnt[i] != wait_cnt_t'(STARVE_MAX)) begin
                    r_wait_cnt[i] <= r_wait_cnt[i] + wait_cnt_t'(1);
                end
            end

            if (i_flush) begin
                r_wb_valid <= '0;
            end else if (!i_wb_stall) begin
                for (int k = 0; k < SUPER; k++) begin
                    r_wb_valid[k] <= w_sel_found[k];
                    if (w_sel_found[k]) begin
                        r_wb_rob[k]  <= io_bus.req_rob[w_sel_idx[k]];
                        r_wb_data[k] <= io_bus.req_data[w_sel_idx[k]];
                        r_wb_src[k]  <= w_sel_idx[k];
                    end
                end
            end
        end
    end

    assign io_bus.wb_valid = r_wb_valid;
    assign io_bus.wb_rob   = r_wb_rob;
    assign io_bus.wb_data  = r_wb_data;
    assign io_bus.wb_src   = r_wb_src;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: table of per-cycle vectors plus hand-built stall/promotion/reset runs.
// Expected writeback snapshots are queued at drive time and checked one cycle later.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    typedef struct {
        logic [2:0] ctl;      // {rst, flush, stall}
        req_mask_t  valid;
        req_mask_t  ready;
        int         n;
        int         s0;
        int         s1;
    } vec_t;

    typedef struct packed {
        logic     [SUPER-1:0] valid;
        src_t     [SUPER-1:0] src;
        rob_idx_t [SUPER-1:0] rob;
        word_t    [SUPER-1:0] data;
    } snap_t;

    logic     clk;
    logic     rst;
    logic     flush;
    logic     wb_stall;

    int       total;
    int       bad;
    snap_t    sb[$];
    snap_t    last;
    rob_idx_t rob_in[NUM_REQ];
    word_t    data_in[NUM_REQ];

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (flush),
        .i_wb_stall (wb_stall),
        .io_bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [2:0] ctl, input req_mask_t v, input req_mask_t rd,
                                input int n, input int s0, input int s1);
        vec_t r;
        r.ctl   = ctl;
        r.valid = v;
        r.ready = rd;
        r.n     = n;
        r.s0    = s0;
        r.s1    = s1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic gen(input int step);
        for (int i = 0; i < NUM_REQ; i++) begin
            rob_in[i]  = rob_idx_t'((step * 5 + i) % ROB_SZ);
            data_in[i] = $urandom();
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        snap_t s;
        snap_t got;
        @(negedge clk);
        rst           = v.ctl[2];
        flush         = v.ctl[1];
        wb_stall      = v.ctl[0];
        bus.req_valid = v.valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_rob[i]  = rob_in[i];
            bus.req_data[i] = data_in[i];
        end
        #1;
        chk({tag, " req_ready"}, 128'(bus.req_ready), 128'(v.ready));

        s = last;
        if (v.ctl[2]) begin
            s = '0;
        end else if (v.ctl[1]) begin
            s.valid = '0;
        end else if (!v.ctl[0]) begin
            s.valid = '0;
            if (v.n > 0) begin
                s.valid[0] = 1'b1;
                s.src[0]   = src_t'(v.s0);
                s.rob[0]   = rob_in[v.s0];
                s.data[0]  = data_in[v.s0];
            end
            if (v.n > 1) begin
                s.valid[1] = 1'b1;
                s.src[1]   = src_t'(v.s1);
                s.rob[1]   = rob_in[v.s1];
                s.data[1]  = data_in[v.s1];
            end
        end
        last = s;
        sb.push_back(s);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, " wb_valid"}, 128'(bus.wb_valid), 128'(got.valid));
        chk({tag, " wb_src"},   128'(bus.wb_src),   128'(got.src));
        chk({tag, " wb_rob"},   128'(bus.wb_rob),   128'(got.rob));
        chk({tag, " wb_data"},  128'(bus.wb_data),  128'(got.data));
    endtask

    initial begin
        vec_t tbl[16];
        total         = 0;
        bad           = 0;
        last          = '0;
        rst           = 1'b1;
        flush         = 1'b0;
        wb_stall      = 1'b0;
        bus.req_valid = '0;
        bus.req_rob   = '0;
        bus.req_data  = '0;

        // Reset with requesters active, then idle.
        gen(100);
        apply(mk(3'b100, 6'h3F, 6'h00, 0, 0, 0), "rst_a");
        apply(mk(3'b100, 6'h3F, 6'h00, 0, 0, 0), "rst_b");
        for (int i = 0; i < 5; i++) begin
            apply(mk(3'b000, 6'h00, 6'h00, 0, 0, 0), $sformatf("idle%0d", i));
        end

        tbl[0]  = mk(3'b000, 6'b111111, 6'b000011, 2, 0, 1);
        tbl[1]  = mk(3'b000, 6'b111111, 6'b001100, 2, 2, 3);
        tbl[2]  = mk(3'b000, 6'b111111, 6'b110000, 2, 4, 5);
        tbl[3]  = mk(3'b000, 6'b000000, 6'b000000, 0, 0, 0);
        tbl[4]  = mk(3'b000, 6'b010000, 6'b010000, 1, 4, 0);
        tbl[5]  = mk(3'b000, 6'b100001, 6'b100001, 2, 5, 0);
        tbl[6]  = mk(3'b000, 6'b001010, 6'b001010, 2, 1, 3);
        tbl[7]  = mk(3'b000, 6'b000111, 6'b000011, 2, 0, 1);
        tbl[8]  = mk(3'b001, 6'b111111, 6'b000000, 0, 0, 0);
        tbl[9]  = mk(3'b001, 6'b111111, 6'b000000, 0, 0, 0);
        tbl[10] = mk(3'b001, 6'b111111, 6'b000000, 0, 0, 0);
        tbl[11] = mk(3'b000, 6'b111111, 6'b001100, 2, 2, 3);
        tbl[12] = mk(3'b010, 6'b001111, 6'b000000, 0, 0, 0);
        tbl[13] = mk(3'b000, 6'b001111, 6'b000011, 2, 0, 1);
        tbl[14] = mk(3'b011, 6'b001111, 6'b000000, 0, 0, 0);
        tbl[15] = mk(3'b000, 6'b001111, 6'b001100, 2, 2, 3);
        for (int r = 0; r < 16; r++) begin
            gen(r);
            apply(tbl[r], $sformatf("row%0d", r));
        end

        // Req 2 ages to STARVE_MAX under stall, then jumps ahead of round-robin order.
        for (int i = 0; i < 7; i++) begin
            gen(20 + i);
            apply(mk(3'b001, 6'b000100, 6'b000000, 0, 0, 0), $sformatf("age%0d", i));
        end
        gen(30);
        apply(mk(3'b000, 6'b110100, 6'b010100, 2, 2, 4), "promo");

        // Six more stall cycles must not promote again: the grant cleared the counter.
        for (int i = 0; i < 6; i++) begin
            gen(40 + i);
            apply(mk(3'b001, 6'b000100, 6'b000000, 0, 0, 0), $sformatf("reage%0d", i));
        end
        gen(50);
        apply(mk(3'b000, 6'b100101, 6'b100001, 2, 5, 0), "no_promo");
        gen(51);
        apply(mk(3'b000, 6'b000110, 6'b000110, 2, 2, 1), "promo2");

        gen(60);
        rob_in[4]  = 5'd9;
        data_in[4] = 32'hDEADBEEF;
        apply(mk(3'b000, 6'b010000, 6'b010000, 1, 4, 0), "single");

        // Reset mid-operation returns the pointer to 0.
        gen(70);
        apply(mk(3'b100, 6'b111111, 6'b000000, 0, 0, 0), "mid_rst");
        gen(71);
        apply(mk(3'b000, 6'b111111, 6'b000011, 2, 0, 1), "post_rst");
        gen(72);
        apply(mk(3'b000, 6'b000000, 6'b000000, 0, 0, 0), "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
